// File: rtl/bram_ctrl_if.sv
// Request/response bus between front-end control logic and bram_ctrl.
// BRAM_CTRL_PARITY_EN adds the parity_err response flag.
interface bram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clr;
  logic              busy;
`ifdef BRAM_CTRL_PARITY_EN
  logic              parity_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, clr,
    input  req_ready, rsp_valid, rsp_rdata, busy, parity_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, clr,
    output req_ready, rsp_valid, rsp_rdata, busy, parity_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, clr,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, clr,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
`endif
endinterface

// File: rtl/bram_ctrl.sv
// Single-port RAM controller: valid/ready requests, 1- or 2-cycle read latency, hardware init/clear sweep.
// Optional macro BRAM_CTRL_PARITY_EN stores an even-parity bit per word and drives bus.parity_err.
//
// state   | meaning
// ST_INIT | writing one word per cycle (address pattern after reset, zeros after clr)
// ST_IDLE | accepting one request per cycle
module bram_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int OUT_REG = 0
) (
  input logic        clk,
  input logic        rst_n,
  bram_ctrl_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
`ifdef BRAM_CTRL_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pat_zero_q, pat_zero_d;
  logic              s1_vld_q, s1_vld_d;
  logic [MEM_W-1:0]  s1_word_q, s1_word_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef BRAM_CTRL_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word, resp_word;
  logic              ready_c, accept, rd_acc, wr_acc, resp_hit;

  function automatic logic [MEM_W-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef BRAM_CTRL_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    pat_zero_d = pat_zero_q;
    ready_c    = (state_q == ST_IDLE) && !bus.clr;
    accept     = bus.req_valid && ready_c;
    wr_acc     = accept && bus.req_we;
    rd_acc     = accept && !bus.req_we;
    rd_word    = mem[bus.req_addr];
    mem_we     = 1'b0;
    mem_addr   = bus.req_addr;
    mem_wdata  = enc(bus.req_wdata);

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = enc(pat_zero_q ? '0 : DATA_W'(ptr_q));
        ptr_d     = ptr_q + ADDR_W'(1);
        if (&ptr_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        mem_we = wr_acc;
        if (bus.clr) begin
          state_d    = ST_INIT;
          ptr_d      = '0;
          pat_zero_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // The read pipeline runs independently of the state so reads survive a clr.
    s1_vld_d  = rd_acc;
    s1_word_d = rd_acc ? rd_word : s1_word_q;
    resp_hit  = (OUT_REG != 0) ? s1_vld_q  : rd_acc;
    resp_word = (OUT_REG != 0) ? s1_word_q : rd_word;

    rsp_valid_d = resp_hit;
    rsp_rdata_d = rsp_rdata_q;
    if (resp_hit)    rsp_rdata_d = resp_word[DATA_W-1:0];
    else if (wr_acc) rsp_rdata_d = '0;
`ifdef BRAM_CTRL_PARITY_EN
    parity_err_d = resp_hit && (resp_word[DATA_W] != ^resp_word[DATA_W-1:0]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      pat_zero_q   <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_word_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
`ifdef BRAM_CTRL_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pat_zero_q   <= pat_zero_d;
      s1_vld_q     <= s1_vld_d;
      s1_word_q    <= s1_word_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef BRAM_CTRL_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign bus.req_ready = ready_c;
  assign bus.busy      = (state_q == ST_INIT);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef BRAM_CTRL_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_bram_ctrl.sv
// Bench for bram_ctrl: an OUT_REG=0 and an OUT_REG=1 instance share one stimulus stream and
// are checked every cycle against a queue-based memory model, plus directed literal checks.
module tb_bram_ctrl;
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       clr = 1'b0;

  always #5 clk = ~clk;

  bram_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
  bram_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

  assign bus0.req_valid = req_valid;  assign bus1.req_valid = req_valid;
  assign bus0.req_we    = req_we;     assign bus1.req_we    = req_we;
  assign bus0.req_addr  = req_addr;   assign bus1.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;  assign bus1.req_wdata = req_wdata;
  assign bus0.clr       = clr;        assign bus1.clr       = clr;

  bram_ctrl #(.DATA_W(8), .ADDR_W(8), .OUT_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bram_ctrl #(.DATA_W(8), .ADDR_W(8), .OUT_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int due; logic [7:0] d; bit p;} rsp_t;
  logic [7:0] mm      [DEPTH];
  bit         corrupt [DEPTH];
  rsp_t       q0[$];
  rsp_t       q1[$];
  int         init_left = DEPTH;
  int         ptr = 0;
  bit         patz = 0;
  int         cyc = 0;
  bit         ev0 = 0, ev1 = 0, ep0 = 0, ep1 = 0;
  logic [7:0] er0 = 8'h00, er1 = 8'h00;

  always @(posedge clk) begin
    bit   acc;
    rsp_t r;
    if (!rst_n) begin
      init_left = DEPTH; ptr = 0; patz = 0;
      q0.delete(); q1.delete();
      ev0 = 0; ev1 = 0; ep0 = 0; ep1 = 0; er0 = 8'h00; er1 = 8'h00;
    end else begin
      cyc++;
      acc = (init_left == 0) && !clr && req_valid;
      if (acc && !req_we) begin
        r.d = mm[req_addr]; r.p = corrupt[req_addr];
        r.due = cyc;     q0.push_back(r);
        r.due = cyc + 1; q1.push_back(r);
      end
      if (acc && req_we) begin
        mm[req_addr] = req_wdata; corrupt[req_addr] = 0;
      end
      if (init_left > 0) begin
        mm[ptr] = patz ? 8'h00 : 8'(ptr); corrupt[ptr] = 0;
        ptr++; init_left--;
      end else if (clr) begin
        init_left = DEPTH; ptr = 0; patz = 1;
      end
      ev0 = 0; ep0 = 0;
      if (q0.size() > 0 && q0[0].due == cyc) begin
        ev0 = 1; er0 = q0[0].d; ep0 = q0[0].p; void'(q0.pop_front());
      end else if (acc && req_we) er0 = 8'h00;
      ev1 = 0; ep1 = 0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        ev1 = 1; er1 = q1[0].d; ep1 = q1[0].p; void'(q1.pop_front());
      end else if (acc && req_we) er1 = 8'h00;
    end
  end

  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = rst_n && (init_left == 0) && !clr;
    chk("m_req_ready0", 32'(bus0.req_ready), 32'(exp_ready));
    chk("m_req_ready1", 32'(bus1.req_ready), 32'(exp_ready));
    chk("m_busy0", 32'(bus0.busy), 32'(init_left > 0));
    chk("m_busy1", 32'(bus1.busy), 32'(init_left > 0));
    chk("m_rsp_valid0", 32'(bus0.rsp_valid), 32'(ev0));
    chk("m_rsp_valid1", 32'(bus1.rsp_valid), 32'(ev1));
    chk("m_rsp_rdata0", 32'(bus0.rsp_rdata), 32'(er0));
    chk("m_rsp_rdata1", 32'(bus1.rsp_rdata), 32'(er1));
`ifdef BRAM_CTRL_PARITY_EN
    if (ev0) chk("m_parity0", 32'(bus0.parity_err), 32'(ep0));
    if (ev1) chk("m_parity1", 32'(bus1.parity_err), 32'(ep1));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid = 1'b0; req_we = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int exp_n);
    int n = 0;
    while (!bus0.req_ready && n < 2000) begin
      step();
      n++;
    end
    if (exp_n >= 0) chk(nm, 32'(n), 32'(exp_n));
    else            chk(nm, 32'(bus0.req_ready), 32'd1);
  endtask

  task automatic rd_lit(input logic [7:0] a, input logic [7:0] e);
    chk("rd_ready", 32'(bus0.req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    step();
    idle_in();
    chk("rd_lat1_valid", 32'(bus0.rsp_valid), 32'd1);
    chk("rd_lat1_data", 32'(bus0.rsp_rdata), 32'(e));
    chk("rd_lat2_early", 32'(bus1.rsp_valid), 32'd0);
    step();
    chk("rd_lat1_pulse", 32'(bus0.rsp_valid), 32'd0);
    chk("rd_lat2_valid", 32'(bus1.rsp_valid), 32'd1);
    chk("rd_lat2_data", 32'(bus1.rsp_rdata), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    step();
    chk("rst_busy", 32'(bus0.busy), 32'd1);
    chk("rst_ready", 32'(bus0.req_ready), 32'd0);
    chk("rst_rdata", 32'(bus1.rsp_rdata), 32'd0);
    step();

    // 1: init sweep length and address pattern
    rst_n = 1'b1;
    wait_ready("init_cycles", 256);
    rd_lit(8'h00, 8'h00);
    rd_lit(8'h7F, 8'h7F);
    rd_lit(8'hFF, 8'hFF);

    // 2: write then back-to-back read
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
    step();
    chk("wr_clears_rdata", 32'(bus0.rsp_rdata), 32'd0);
    rd_lit(8'h10, 8'hA5);

    // 3: four back-to-back reads through the 2-cycle pipeline
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(k);
      end else idle_in();
      step();
      chk("b2b_valid", 32'(bus1.rsp_valid), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) chk("b2b_data", 32'(bus1.rsp_rdata), 32'(k - 1));
    end
    idle_in();

    // 4: clr blocks the request, in-flight read completes, zero-fill
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
    step();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_wdata = 8'h77; clr = 1'b1;
    #1;
    chk("clr_blocks_ready", 32'(bus0.req_ready), 32'd0);
    step();
    idle_in();
    chk("clr_busy", 32'(bus0.busy), 32'd1);
    chk("clr_inflight_valid", 32'(bus1.rsp_valid), 32'd1);
    chk("clr_inflight_data", 32'(bus1.rsp_rdata), 32'h05);
    n = 0;
    while (bus0.busy && n < 2000) begin
      step();
      n++;
    end
    chk("clr_busy_cycles", 32'(n), 32'd256);
    rd_lit(8'h10, 8'h00);
    rd_lit(8'hFF, 8'h00);

    // 5: reset in the middle of the sweep
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (100) step();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_valid", 32'(bus1.rsp_valid), 32'd0);
      chk("midrst_busy", 32'(bus0.busy), 32'd1);
    end
    rst_n = 1'b1;
    wait_ready("resweep_cycles", 256);
    rd_lit(8'h80, 8'h80);

`ifdef BRAM_CTRL_PARITY_EN
    // 6: corrupt one stored data bit without touching its parity
    dut0.mem[8'h20][0] = ~dut0.mem[8'h20][0];
    dut1.mem[8'h20][0] = ~dut1.mem[8'h20][0];
    mm[8'h20] = mm[8'h20] ^ 8'h01;
    corrupt[8'h20] = 1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20;
    step();
    req_addr = 8'h21;
    chk("par_err0", 32'(bus0.parity_err), 32'd1);
    chk("par_err0_valid", 32'(bus0.rsp_valid), 32'd1);
    step();
    idle_in();
    chk("par_ok0", 32'(bus0.parity_err), 32'd0);
    chk("par_err1", 32'(bus1.parity_err), 32'd1);
    step();
    chk("par_ok1", 32'(bus1.parity_err), 32'd0);
`endif

    // randomized traffic, including clr pulses and short resets
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      rst_n     = !(r < 2);
      clr       = (r >= 2 && r < 8);
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = ($urandom_range(0, 9) < 4);
      req_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(16, 23));
      req_wdata = 8'($urandom);
      step();
    end
    idle_in();
    rst_n = 1'b1;
    wait_ready("final_ready", -1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
